dmem_arbiter: RTL and testbench

//   Shares one word-wide data memory between two requesters: the pipeline
//   MEM stage (core port) and a DMA/debug master (DMA port).
//   - Arbitrates round-robin between the two ports.
//   - Turns core byte/half stores into a read-modify-write, because the

---
 rtl/dmem_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one word-wide data memory between the core MEM
// stage and a DMA/debug master; core byte/half stores become read-modify-write.
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    // core port
    input  logic              c_req,
    input  logic              c_we,
    input  logic [1:0]        c_size,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_ack,
    output logic [DATA_W-1:0] c_rdata,
    output logic              c_err,
    output logic              c_stall,
    // DMA port
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    // memory side
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_wa,
    output logic [ADDR_W-1:0] mem_ra,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd
);

    localparam int LANES = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        WR   = 2'd2
    } state_t;

    state_t state_reg, state_next;

    // Latched request; everything on the memory side is decoded from these.
    logic              sel_dma_reg;
    logic              last_dma_reg;
    logic              we_reg;
    logic [1:0]        size_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [DATA_W-1:0] merged_reg;

    logic              c_ack_reg, d_ack_reg, c_err_reg;
    logic [DATA_W-1:0] c_rdata_reg, d_rdata_reg;

    logic              grant_core, grant_dma;
    logic              mem_we_int;
    logic              c_ack_next, d_ack_next, c_err_next;
    logic              c_rd_load, d_rd_load, merge_load;

    logic              is_half, is_byte, word_store, misaligned;
    logic [LANES-1:0]  lane_en;
    logic [DATA_W-1:0] merged_word;

    assign is_half    = (size_reg == 2'b01);
    assign is_byte    = (size_reg == 2'b10);
    assign word_store = sel_dma_reg || !(is_half || is_byte);
    assign misaligned = !sel_dma_reg && is_half && addr_reg[0];

    // Lane merge: the new byte/half replaces its lane(s), the rest come from the old word.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [7:0] src_byte;
            assign lane_en[gi] = is_byte ? (addr_reg[1:0] == 2'(gi))
                                         : (addr_reg[1] == 1'(gi / 2));
            assign src_byte = (is_half && ((gi % 2) == 1)) ? wdata_reg[15:8]
                                                           : wdata_reg[7:0];
            assign merged_word[8*gi +: 8] = lane_en[gi] ? src_byte
                                                        : mem_rd[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        grant_core = 1'b0;
        grant_dma  = 1'b0;
        mem_we_int = 1'b0;
        c_ack_next = 1'b0;
        d_ack_next = 1'b0;
        c_err_next = 1'b0;
        c_rd_load  = 1'b0;
        d_rd_load  = 1'b0;
        merge_load = 1'b0;
        unique case (state_reg)
            IDLE: begin
                // Contention goes to whichever port was not granted last.
                if (c_req && (!d_req || last_dma_reg)) begin
                    grant_core = 1'b1;
                    state_next = ACC;
                end else if (d_req) begin
                    grant_dma  = 1'b1;
                    state_next = ACC;
                end
            end
            ACC: begin
                state_next = IDLE;
                if (!we_reg) begin
                    if (sel_dma_reg) begin
                        d_ack_next = 1'b1;
                        d_rd_load  = 1'b1;
                    end else begin
                        c_ack_next = 1'b1;
                        c_rd_load  = 1'b1;
                    end
                end else if (word_store) begin
                    mem_we_int = 1'b1;
                    if (sel_dma_reg) begin
                        d_ack_next = 1'b1;
                    end else begin
                        c_ack_next = 1'b1;
                    end
                end else if (misaligned) begin
                    c_ack_next = 1'b1;
                    c_err_next = 1'b1;
                end else begin
                    merge_load = 1'b1;
                    state_next = WR;
                end
            end
            WR: begin
                mem_we_int = 1'b1;
                c_ack_next = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_dma_reg  <= 1'b0;
            last_dma_reg <= 1'b1;
            we_reg       <= 1'b0;
            size_reg     <= 2'b00;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            merged_reg   <= '0;
        end else begin
            if (grant_core) begin
                sel_dma_reg  <= 1'b0;
                last_dma_reg <= 1'b0;
                we_reg       <= c_we;
                size_reg     <= c_size;
                addr_reg     <= c_addr;
                wdata_reg    <= c_wdata;
            end else if (grant_dma) begin
                // DMA is word-only, so its size is forced to word.
                sel_dma_reg  <= 1'b1;
                last_dma_reg <= 1'b1;
                we_reg       <= d_we;
                size_reg     <= 2'b00;
                addr_reg     <= d_addr;
                wdata_reg    <= d_wdata;
            end
            if (merge_load) begin
                merged_reg <= merged_word;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_ack_reg   <= 1'b0;
            d_ack_reg   <= 1'b0;
            c_err_reg   <= 1'b0;
            c_rdata_reg <= '0;
            d_rdata_reg <= '0;
        end else begin
            c_ack_reg <= c_ack_next;
            d_ack_reg <= d_ack_next;
            c_err_reg <= c_err_next;
            if (c_rd_load) begin
                c_rdata_reg <= mem_rd;
            end
            if (d_rd_load) begin
                d_rdata_reg <= mem_rd;
            end
        end
    end

    assign c_ack   = c_ack_reg;
    assign d_ack   = d_ack_reg;
    assign c_err   = c_err_reg;
    assign c_rdata = c_rdata_reg;
    assign d_rdata = d_rdata_reg;
    assign c_stall = c_req & ~c_ack_reg;

    assign mem_we = mem_we_int;
    assign mem_wa = {addr_reg[ADDR_W-1:2], 2'b00};
    assign mem_ra = {addr_reg[ADDR_W-1:2], 2'b00};
    assign mem_wd = (state_reg == WR) ? merged_reg : wdata_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a small word memory model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        c_req = 1'b0, c_we = 1'b0;
    logic [1:0]  c_size = 2'b00;
    logic [31:0] c_addr = '0, c_wdata = '0;
    logic        c_ack, c_err, c_stall;
    logic [31:0] c_rdata;
    logic        d_req = 1'b0, d_we = 1'b0;
    logic [31:0] d_addr = '0, d_wdata = '0;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        mem_we;
    logic [31:0] mem_wa, mem_ra, mem_wd, mem_rd;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .c_req(c_req), .c_we(c_we), .c_size(c_size), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_ack(c_ack), .c_rdata(c_rdata), .c_err(c_err), .c_stall(c_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_we(mem_we), .mem_wa(mem_wa), .mem_ra(mem_ra), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    // Memory model: combinational read, write on the clock edge; backdoor preload when idle.
    logic [31:0] mem [0:63];
    logic        bd_we = 1'b0;
    logic [5:0]  bd_idx = '0;
    logic [31:0] bd_data = '0;

    assign mem_rd = mem[mem_ra[7:2]];

    always @(posedge clk) begin
        if (mem_we) mem[mem_wa[7:2]] <= mem_wd;
        else if (bd_we) mem[bd_idx] <= bd_data;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mem_poke(input logic [5:0] idx, input logic [31:0] data);
        bd_idx = idx; bd_data = data; bd_we = 1'b1;
        step();
        bd_we = 1'b0;
    endtask

    task automatic apply_reset();
        c_req = 1'b0; d_req = 1'b0;
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
    endtask

    // Counts edges until an ack is seen; -1 on timeout.
    task automatic wait_d_ack(output int n);
        n = -1;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (d_ack) begin n = i; break; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        total++;
        if ({c_ack, d_ack, c_err, mem_we, c_stall} !== 5'b0) $display("FAIL reset_flags: got %b required 00000", {c_ack, d_ack, c_err, mem_we, c_stall});
        else passed++;
        step(); step();
        total++;
        if ({c_rdata, d_rdata} !== 64'h0) $display("FAIL reset_rdata: got %h required 0", {c_rdata, d_rdata});
        else passed++;
        total++;
        if ({mem_wa, mem_ra, mem_wd} !== 96'h0) $display("FAIL reset_mem_bus: got %h required 0", {mem_wa, mem_ra, mem_wd});
        else passed++;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_core_load();
        mem_poke(6'h04, 32'hDEADBEEF);
        c_we = 1'b0; c_size = 2'b10; c_addr = 32'h10; c_req = 1'b1;
        #1;
        total++;
        if (c_stall !== 1'b1) $display("FAIL load_stall_pre: got %b required 1", c_stall);
        else passed++;
        step();
        total++;
        if ({c_ack, c_stall, mem_ra} !== {1'b0, 1'b1, 32'h10}) $display("FAIL load_acc: got ack=%b stall=%b ra=%h required 0 1 00000010", c_ack, c_stall, mem_ra);
        else passed++;
        step();
        total++;
        if ({c_ack, c_stall} !== 2'b10) $display("FAIL load_ack: got ack=%b stall=%b required 1 0", c_ack, c_stall);
        else passed++;
        total++;
        if (c_rdata !== 32'hDEADBEEF) $display("FAIL load_rdata: got %h required deadbeef", c_rdata);
        else passed++;
        c_req = 1'b0;
        step();
        total++;
        if (c_ack !== 1'b0) $display("FAIL load_ack_pulse: got %b required 0", c_ack);
        else passed++;
    endtask

    task automatic test_sub_word_store();
        mem_poke(6'h08, 32'h11223344);
        c_we = 1'b1; c_size = 2'b10; c_addr = 32'h22; c_wdata = 32'h000000AB; c_req = 1'b1;
        step();
        total++;
        if ({mem_we, c_ack} !== 2'b00) $display("FAIL sb_acc: got we=%b ack=%b required 0 0", mem_we, c_ack);
        else passed++;
        step();
        total++;
        if ({mem_we, c_ack, mem_wa, mem_wd} !== {1'b1, 1'b0, 32'h20, 32'h11AB3344}) $display("FAIL sb_wr: got we=%b ack=%b wa=%h wd=%h required 1 0 00000020 11ab3344", mem_we, c_ack, mem_wa, mem_wd);
        else passed++;
        step();
        total++;
        if ({c_ack, c_err, mem_we} !== 3'b100) $display("FAIL sb_ack: got ack=%b err=%b we=%b required 1 0 0", c_ack, c_err, mem_we);
        else passed++;
        total++;
        if (mem[8] !== 32'h11AB3344) $display("FAIL sb_mem: got %h required 11ab3344", mem[8]);
        else passed++;
        total++;
        if (c_rdata !== 32'hDEADBEEF) $display("FAIL rdata_hold: got %h required deadbeef", c_rdata);
        else passed++;
        c_req = 1'b0;
        step();
    endtask

    task automatic test_misaligned();
        c_we = 1'b1; c_size = 2'b01; c_addr = 32'h21; c_wdata = 32'h00007777; c_req = 1'b1;
        step();
        total++;
        if (mem_we !== 1'b0) $display("FAIL mis_we_acc: got %b required 0", mem_we);
        else passed++;
        step();
        total++;
        if ({c_ack, c_err, mem_we} !== 3'b110) $display("FAIL mis_ack: got ack=%b err=%b we=%b required 1 1 0", c_ack, c_err, mem_we);
        else passed++;
        c_req = 1'b0;
        step();
        total++;
        if ({c_ack, c_err} !== 2'b00) $display("FAIL mis_err_pulse: got ack=%b err=%b required 0 0", c_ack, c_err);
        else passed++;
        total++;
        if (mem[8] !== 32'h11AB3344) $display("FAIL mis_mem: got %h required 11ab3344", mem[8]);
        else passed++;
    endtask

    task automatic test_half_store();
        c_we = 1'b1; c_size = 2'b01; c_addr = 32'h22; c_wdata = 32'hFFFF5566; c_req = 1'b1;
        step(); step();
        total++;
        if (mem_wd !== 32'h55663344) $display("FAIL sh_wd: got %h required 55663344", mem_wd);
        else passed++;
        step();
        total++;
        if ({c_ack, c_err} !== 2'b10) $display("FAIL sh_ack: got ack=%b err=%b required 1 0", c_ack, c_err);
        else passed++;
        c_req = 1'b0;
        step();
        total++;
        if (mem[8] !== 32'h55663344) $display("FAIL sh_mem: got %h required 55663344", mem[8]);
        else passed++;
    endtask

    task automatic test_round_robin();
        int order [4];
        int got;
        got = 0;
        apply_reset();
        c_we = 1'b0; c_addr = 32'h10; d_we = 1'b0; d_addr = 32'h20;
        c_req = 1'b1; d_req = 1'b1;
        for (int i = 0; i < 20 && got < 4; i++) begin
            step();
            if (c_ack) begin order[got] = 0; got++; end
            else if (d_ack) begin order[got] = 1; got++; end
        end
        c_req = 1'b0; d_req = 1'b0;
        total++;
        if (got !== 4) $display("FAIL rr_count: got %0d acks required 4", got);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (order[i] !== (i % 2)) $display("FAIL rr_order[%0d]: got port %0d required %0d (0=core 1=dma)", i, order[i], i % 2);
            else passed++;
        end
        step();
    endtask

    task automatic test_dma_rw();
        int n;
        d_we = 1'b1; d_addr = 32'h0; d_wdata = 32'hCAFEF00D; d_req = 1'b1;
        wait_d_ack(n);
        d_req = 1'b0;
        total++;
        if (n !== 2) $display("FAIL dma_wr_latency: got %0d edges required 2", n);
        else passed++;
        total++;
        if (mem[0] !== 32'hCAFEF00D) $display("FAIL dma_wr_mem: got %h required cafef00d", mem[0]);
        else passed++;
        step();
        d_we = 1'b0; d_addr = 32'h0; d_req = 1'b1;
        wait_d_ack(n);
        d_req = 1'b0;
        total++;
        if (d_rdata !== 32'hCAFEF00D) $display("FAIL dma_rd0: got %h required cafef00d (edges %0d)", d_rdata, n);
        else passed++;
        step();
        mem_poke(6'h01, 32'h99999999);
        d_addr = 32'h3; d_req = 1'b1;
        wait_d_ack(n);
        d_req = 1'b0;
        total++;
        if (d_rdata !== 32'hCAFEF00D) $display("FAIL dma_rd3: got %h required cafef00d (edges %0d)", d_rdata, n);
        else passed++;
        step();
    endtask

    task automatic test_reset_during_wr();
        bit seen;
        mem_poke(6'h0C, 32'h01020304);
        c_we = 1'b1; c_size = 2'b10; c_addr = 32'h31; c_wdata = 32'h000000EE; c_req = 1'b1;
        step(); step();
        total++;
        if (mem_we !== 1'b1) $display("FAIL rst_wr_we: got %b required 1", mem_we);
        else passed++;
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if ({mem_we, c_ack} !== 2'b00) $display("FAIL rst_wr_drop: got we=%b ack=%b required 0 0", mem_we, c_ack);
        else passed++;
        c_req = 1'b0;
        step();
        total++;
        if (c_ack !== 1'b0) $display("FAIL rst_wr_noack: got %b required 0", c_ack);
        else passed++;
        total++;
        if (mem[12] !== 32'h01020304) $display("FAIL rst_wr_mem: got %h required 01020304", mem[12]);
        else passed++;
        rst_n = 1'b1;
        c_we = 1'b0; c_addr = 32'h10; d_we = 1'b0; d_addr = 32'h20;
        c_req = 1'b1; d_req = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            if (c_ack || d_ack) seen = 1'b1;
        end
        c_req = 1'b0; d_req = 1'b0;
        total++;
        if ({seen, c_ack, d_ack} !== 3'b110) $display("FAIL rst_first_grant: got seen=%b c_ack=%b d_ack=%b required 1 1 0", seen, c_ack, d_ack);
        else passed++;
        step();
    endtask

    initial begin
        test_reset();
        test_core_load();
        test_sub_word_store();
        test_misaligned();
        test_half_store();
        test_round_robin();
        test_dma_rw();
        test_reset_during_wr();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
